// File: rtl/sobel_filter.sv
// -----------------------------------------------------------------------------
// sobel_filter
//   Streaming 3x3 Sobel edge-magnitude stage of the edge_detect pipeline.
//   Pops 8-bit grayscale pixels in raster order from an upstream FIFO and
//   pushes exactly one 8-bit edge pixel per input pixel to a downstream FIFO.
//   A 2*WIDTH+3 entry pixel history (newest first) keeps the full 3x3 window
//   available at every raster position.
//
//   Optional build macro: SOBEL_THRESHOLD_EN
//     defined   -> interior outputs are binarized: 255 if the clamped
//                  magnitude >= THRESHOLD, else 0.
//     undefined -> the clamped magnitude is output unchanged.
//
// Parameters
//   WIDTH      pixels per line (>= 3)
//   HEIGHT     lines per frame (>= 3)
//   THRESHOLD  binarization level (only with SOBEL_THRESHOLD_EN)
//
// Ports
//   clock      in   rising-edge clock
//   reset      in   asynchronous, active-high reset
//   in_dout    in   [7:0] pixel at the head of the upstream FIFO
//   in_empty   in   upstream FIFO empty
//   in_rd_en   out  pop upstream FIFO this cycle
//   out_din    out  [7:0] edge pixel to the downstream FIFO
//   out_full   in   downstream FIFO full
//   out_wr_en  out  push out_din this cycle
//
// Handshake: a pixel is consumed on a rising clock edge where in_rd_en is 1
// (which implies in_empty was 0); a result is delivered on a rising edge where
// out_wr_en is 1 (which implies out_full was 0). Both enables are
// combinational, so a result is pushed in the same cycle as the pop that
// completes its window.
// -----------------------------------------------------------------------------
module sobel_filter #(
  parameter int WIDTH     = 720,
  parameter int HEIGHT    = 540,
  parameter int THRESHOLD = 128
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] in_dout,
  input  logic       in_empty,
  output logic       in_rd_en,
  output logic [7:0] out_din,
  input  logic       out_full,
  output logic       out_wr_en
);

  localparam int TOTAL = WIDTH * HEIGHT;
  localparam int HIST  = 2 * WIDTH + 3;
  localparam int CW    = $clog2(TOTAL);
  localparam int RW    = $clog2(HEIGHT);
  localparam int COLW  = $clog2(WIDTH);

  localparam logic [CW-1:0]   LAST_IN  = CW'(TOTAL - 1);
  localparam logic [CW-1:0]   FILL_END = CW'(WIDTH);
  localparam logic [RW-1:0]   LAST_ROW = RW'(HEIGHT - 1);
  localparam logic [COLW-1:0] LAST_COL = COLW'(WIDTH - 1);

  // S_FILL : priming the history, nothing emitted
  // S_RUN  : one pop and one push per transfer
  // S_FLUSH: drain the final WIDTH+1 outputs by shifting in zeros
  typedef enum logic [1:0] {
    S_FILL  = 2'd0,
    S_RUN   = 2'd1,
    S_FLUSH = 2'd2
  } state_t;

  state_t          state;
  logic [7:0]      hist [HIST];
  logic [CW-1:0]   in_count;
  logic [RW-1:0]   out_row;
  logic [COLW-1:0] out_col;

  logic       shift;
  logic [7:0] shift_in;
  logic       last_pos;
  logic       interior;

  // ---------------------------------------------------------------------------
  // Handshake enables
  // ---------------------------------------------------------------------------
  always_comb begin
    in_rd_en  = 1'b0;
    out_wr_en = 1'b0;
    if (!reset) begin
      case (state)
        S_FILL: in_rd_en = !in_empty;
        S_RUN: begin
          in_rd_en  = !in_empty && !out_full;
          out_wr_en = !in_empty && !out_full;
        end
        S_FLUSH: out_wr_en = !out_full;
        default: ;
      endcase
    end
  end

  // In S_RUN pop and push coincide; in S_FLUSH only the push happens.
  assign shift    = in_rd_en || out_wr_en;
  assign shift_in = (state == S_FLUSH) ? 8'd0 : in_dout;
  assign last_pos = (out_row == LAST_ROW) && (out_col == LAST_COL);
  assign interior = (out_row != '0) && (out_row != LAST_ROW) &&
                    (out_col != '0) && (out_col != LAST_COL);

  // ---------------------------------------------------------------------------
  // 3x3 window, taken from the history as it will look after this cycle's
  // shift: entry 0 is the incoming pixel and entry k is hist[k-1]. That makes
  // the window centre (entry WIDTH+1) the pixel at (out_row, out_col).
  //   pRC : R = 0 row above, 1 centre row, 2 row below; C = 0 left .. 2 right
  // ---------------------------------------------------------------------------
  logic [7:0] p00, p01, p02, p10, p12, p20, p21, p22;

  assign p22 = shift_in;
  assign p21 = hist[0];
  assign p20 = hist[1];
  assign p12 = hist[WIDTH-1];
  assign p10 = hist[WIDTH+1];
  assign p02 = hist[2*WIDTH-1];
  assign p01 = hist[2*WIDTH];
  assign p00 = hist[2*WIDTH+1];

  // Each weighted sum is at most 4*255 = 1020, so 11 bits hold it and the
  // 11-bit difference is the correct two's-complement gradient.
  logic [10:0] gx_pos, gx_neg, gy_pos, gy_neg;
  logic [10:0] gx, gy, abs_x, abs_y;
  logic [11:0] magnitude;
  logic [7:0]  clamped;
  logic [7:0]  edge_val;

  always_comb begin
    gx_pos = {3'b0, p02} + {2'b0, p12, 1'b0} + {3'b0, p22};
    gx_neg = {3'b0, p00} + {2'b0, p10, 1'b0} + {3'b0, p20};
    gy_pos = {3'b0, p20} + {2'b0, p21, 1'b0} + {3'b0, p22};
    gy_neg = {3'b0, p00} + {2'b0, p01, 1'b0} + {3'b0, p02};
    gx     = gx_pos - gx_neg;
    gy     = gy_pos - gy_neg;
    // |G| <= 1020, so negating never hits the -1024 corner case.
    abs_x  = gx[10] ? (11'd0 - gx) : gx;
    abs_y  = gy[10] ? (11'd0 - gy) : gy;
    magnitude = {1'b0, abs_x} + {1'b0, abs_y};
    clamped   = (magnitude > 12'd255) ? 8'd255 : magnitude[7:0];
  end

`ifdef SOBEL_THRESHOLD_EN
  localparam logic [8:0] THR9 = 9'(THRESHOLD);
  assign edge_val = ({1'b0, clamped} >= THR9) ? 8'd255 : 8'd0;
`else
  assign edge_val = clamped;
`endif

  assign out_din = (!reset && interior) ? edge_val : 8'd0;

  // ---------------------------------------------------------------------------
  // History, counters and FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= S_FILL;
      in_count <= '0;
      out_row  <= '0;
      out_col  <= '0;
      for (int i = 0; i < HIST; i++) hist[i] <= 8'd0;
    end else begin
      if (shift) begin
        hist[0] <= shift_in;
        for (int i = 1; i < HIST; i++) hist[i] <= hist[i-1];
      end

      if (in_rd_en)
        in_count <= (in_count == LAST_IN) ? '0 : in_count + 1'b1;

      if (out_wr_en) begin
        if (out_col == LAST_COL) begin
          out_col <= '0;
          out_row <= (out_row == LAST_ROW) ? '0 : out_row + 1'b1;
        end else begin
          out_col <= out_col + 1'b1;
        end
      end

      case (state)
        S_FILL:
          if (in_rd_en && (in_count == FILL_END)) state <= S_RUN;
        S_RUN:
          if (in_rd_en && (in_count == LAST_IN)) state <= S_FLUSH;
        S_FLUSH:
          // The final raster position is the (WIDTH+1)th flush push.
          if (out_wr_en && last_pos) begin
            state    <= S_FILL;
            in_count <= '0;
            out_row  <= '0;
            out_col  <= '0;
          end
        default: state <= S_FILL;
      endcase
    end
  end

endmodule
